fifo_sched: RTL and testbench



---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_sched_rr_arbiter.sv | 28 ++
 rtl/fifo_sched.sv | 109 ++++++++++
 tb/tb_fifo_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO scheduler: data width, FIFO depth and
// the push/pop turn encoding used when both operations compete.
package fifo_pkg;

    localparam int DW    = 8;
    localparam int DEPTH = 10;

    typedef enum logic {
        PUSH_TURN = 1'b0,
        POP_TURN  = 1'b1
    } turn_t;

endpackage

// File: rtl/fifo_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// when searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   winner
);

    logic found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && req[(int'(ptr) + off) % NREQ]) begin
                found                             = 1'b1;
                gnt[(int'(ptr) + off) % NREQ]     = 1'b1;
                winner                            = PW'((int'(ptr) + off) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_sched.sv
// Shares a single-port FIFO between NREQ producers and one stream consumer,
// issuing at most one FIFO operation per cycle and skid-buffering read data.
module fifo_sched
    import fifo_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready,
    output logic               fifo_clear,
    output logic               fifo_push,
    output logic               fifo_pop,
    output logic [DW-1:0]      fifo_data_in,
    input  logic [DW-1:0]      fifo_data_out,
    input  logic               fifo_full,
    input  logic               fifo_empty
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [NREQ-1:0] arb_gnt;
    turn_t           turn;
    turn_t           turn_nxt;
    logic            pend;
    logic [1:0]      clr_cnt;
    logic [DW-1:0]   skid [2];
    logic            wr_idx;
    logic            rd_idx;
    logic [1:0]      count;
    logic [1:0]      count_after;
    logic            accept;
    logic            push_cand;
    logic            pop_cand;
    logic            do_push;
    logic            do_pop;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign out_valid   = (count != 2'd0);
    assign out_data    = out_valid ? skid[rd_idx] : '0;
    assign accept      = out_valid && out_ready;
    assign count_after = count - {1'b0, accept};

    // The pop reservation counts the word still in flight from the FIFO, so
    // the skid buffer can never be asked to hold a third entry.
    always_comb begin
        push_cand    = (|req) && !fifo_full && !fifo_clear;
        pop_cand     = !fifo_empty && !fifo_clear &&
                       (({1'b0, count_after} + {2'b00, pend}) < 3'd2);
        do_push      = push_cand && (!pop_cand || (turn == PUSH_TURN));
        do_pop       = pop_cand && (!push_cand || (turn == POP_TURN));
        turn_nxt     = turn;
        if (push_cand && pop_cand) begin
            turn_nxt = (turn == PUSH_TURN) ? POP_TURN : PUSH_TURN;
        end
        gnt          = do_push ? arb_gnt : '0;
        fifo_push    = do_push;
        fifo_pop     = do_pop;
        fifo_data_in = do_push ? req_data[int'(winner)*DW +: DW] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            turn       <= PUSH_TURN;
            pend       <= 1'b0;
            clr_cnt    <= 2'd2;
            fifo_clear <= 1'b1;
            skid[0]    <= '0;
            skid[1]    <= '0;
            wr_idx     <= 1'b0;
            rd_idx     <= 1'b0;
            count      <= 2'd0;
        end else begin
            fifo_clear <= (clr_cnt > 2'd1);
            if (clr_cnt != 2'd0) begin
                clr_cnt <= clr_cnt - 2'd1;
            end
            if (do_push) begin
                rr_ptr <= PW'((int'(winner) + 1) % NREQ);
            end
            turn <= turn_nxt;
            pend <= do_pop;
            // FIFO read data is only valid the cycle after the pop edge.
            if (pend) begin
                skid[wr_idx] <= fifo_data_out;
                wr_idx       <= ~wr_idx;
            end
            if (accept) begin
                rd_idx <= ~rd_idx;
            end
            count <= count_after + {1'b0, pend};
        end
    end

endmodule

// File: tb/tb_fifo_sched.sv
// Randomized scoreboard bench for fifo_sched with a behavioural FIFO and
// a queue-based reference model of scheduling, ordering and clear timing.
module tb_fifo_sched;
    import fifo_pkg::*;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_ready = 1'b0;
    logic               fifo_clear;
    logic               fifo_push;
    logic               fifo_pop;
    logic [DW-1:0]      fifo_data_in;
    logic [DW-1:0]      fifo_data_out = '0;
    logic               fifo_full;
    logic               fifo_empty;

    int errors = 0;
    int checks = 0;

    fifo_sched #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .fifo_clear    (fifo_clear),
        .fifo_push     (fifo_push),
        .fifo_pop      (fifo_pop),
        .fifo_data_in  (fifo_data_in),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    // Behavioural single-port FIFO: a pop in the same cycle as a push is dropped.
    logic [DW-1:0] fmem [DEPTH];
    int fcnt = 0;
    int fwp  = 0;
    int frp  = 0;

    always @(posedge clk) begin
        if (fifo_clear) begin
            fcnt <= 0;
            fwp  <= 0;
            frp  <= 0;
        end else if (fifo_push) begin
            if (fcnt < DEPTH) begin
                fmem[fwp] <= fifo_data_in;
                fwp       <= (fwp + 1) % DEPTH;
                fcnt      <= fcnt + 1;
            end
        end else if (fifo_pop && fcnt > 0) begin
            fifo_data_out <= fmem[frp];
            frp           <= (frp + 1) % DEPTH;
            fcnt          <= fcnt - 1;
        end
    end

    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: words buffered downstream, word in flight,
    // edges since reset release, and the producer words awaiting output.
    int            m_ptr = 0;
    bit            m_turn_pop = 1'b0;
    int            m_skid = 0;
    int            m_inflight = 0;
    int            m_rel = 0;
    logic [DW-1:0] exp_q [$];
    logic [NREQ-1:0] granted_last = '0;

    always @(negedge clk) begin
        bit   clear_exp, acc, push_c, pop_c, iss_push, iss_pop;
        int   w;
        logic [31:0] exp_gnt;
        logic [31:0] exp_din;
        if (!reset) begin
            check_output("reset_fifo_clear", fifo_clear, 1);
            check_output("reset_gnt", gnt, 0);
            check_output("reset_push", fifo_push, 0);
            check_output("reset_pop", fifo_pop, 0);
            check_output("reset_out_valid", out_valid, 0);
            check_output("reset_out_data", out_data, 0);
            m_ptr = 0;
            m_turn_pop = 1'b0;
            m_skid = 0;
            m_inflight = 0;
            m_rel = 0;
            exp_q.delete();
            granted_last = '0;
        end else begin
            clear_exp = (m_rel < 2);
            acc       = (m_skid != 0) && out_ready;
            push_c    = (req != '0) && !fifo_full && !clear_exp;
            pop_c     = !fifo_empty && !clear_exp && ((m_skid - int'(acc) + m_inflight) < 2);
            w = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (w < 0 && req[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
            end
            iss_push = push_c && (!pop_c || !m_turn_pop);
            iss_pop  = pop_c && (!push_c || m_turn_pop);
            exp_gnt  = iss_push ? (32'd1 << w) : 32'd0;
            exp_din  = iss_push ? 32'(req_data[w*DW +: DW]) : 32'd0;
            check_output("fifo_clear", fifo_clear, 32'(clear_exp));
            check_output("out_valid", out_valid, 32'(m_skid != 0));
            check_output("fifo_push", fifo_push, 32'(iss_push));
            check_output("fifo_pop", fifo_pop, 32'(iss_pop));
            check_output("gnt", gnt, exp_gnt);
            check_output("fifo_data_in", fifo_data_in, exp_din);
            if (iss_push) begin
                exp_q.push_back(req_data[w*DW +: DW]);
                m_ptr = (w + 1) % NREQ;
            end
            if (push_c && pop_c) m_turn_pop = !m_turn_pop;
            m_skid     = m_skid - int'(acc) + m_inflight;
            m_inflight = int'(iss_pop);
            if (m_rel < 2) m_rel++;
            granted_last = gnt;
        end
    end

    // Output monitor: every accepted word must be the oldest granted one.
    always @(negedge clk) begin
        logic [DW-1:0] exp_word;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL out_unexpected: got 0x%0h expected no word at %0t", out_data, $time);
            end else begin
                exp_word = exp_q.pop_front();
                check_output("out_data", out_data, 32'(exp_word));
            end
        end
    end

    task automatic apply_stimulus(input int req_pct, input int ready_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (granted_last[i] || !req[i]) begin
                req[i]               = ($urandom_range(99) < req_pct);
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
        out_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic run_cycles(input int n, input int req_pct, input int ready_pct);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply_stimulus(req_pct, ready_pct);
        end
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        run_cycles(40, 100, 0);
        run_cycles(200, 60, 100);
        run_cycles(400, 50, 50);

        waited = 0;
        while (m_inflight != 1 && waited < 200) begin
            run_cycles(1, 60, 50);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pend: got no pop within 200 cycles expected a pop");
        end
        #1 reset = 1'b0;
        #1;
        check_output("async_reset_out_valid", out_valid, 0);
        check_output("async_reset_out_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        run_cycles(300, 50, 50);
        run_cycles(60, 0, 100);
        check_output("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
